// File: rtl/sonic_echo_responder.sv
// Responder side of an ultrasonic trigger/echo ranging link: accepts a trigger pulse,
// waits a burst delay, then returns an echo pulse whose width encodes distance_cm.
module sonic_echo_responder #(
  parameter int unsigned DIST_W       = 9,
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned TRIG_MIN_CYC = 1000,
  parameter int unsigned BURST_CYC    = 20000,
  parameter int unsigned CYC_PER_CM   = 5883,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = 3800000,
  parameter int unsigned HOLDOFF_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              out_of_range,
  output logic              short_trig,
  output logic              ignored_trig
);

  localparam int unsigned PROD_W = DIST_W + CNT_W;

  localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TRIG_MIN   = CNT_W'(TRIG_MIN_CYC);
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLDOFF_CYC);
  localparam logic [CNT_W-1:0]  TIMEOUT_W  = CNT_W'(TIMEOUT_CYC);
  localparam logic [DIST_W-1:0] MAX_D      = DIST_W'(MAX_CM);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t             state;
  logic               trig_m;
  logic               trig_s;
  logic               trig_s_d;
  logic               rise;
  logic               fall;
  logic [CNT_W-1:0]   cnt;
  logic [DIST_W-1:0]  dist_q;
  logic [CNT_W-1:0]   width_q;
  logic               in_range;
  logic [PROD_W-1:0]  prod;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      trig_s_d <= 1'b0;
    end else begin
      trig_m   <= trig;
      trig_s   <= trig_m;
      trig_s_d <= trig_s;
    end
  end

  assign rise     = trig_s & ~trig_s_d;
  assign fall     = ~trig_s & trig_s_d;
  assign in_range = (dist_q != '0) && (dist_q <= MAX_D);
  assign prod     = PROD_W'(dist_q) * PROD_W'(CYC_PER_CM);

  // Acceptance happens in the cycle the fall is seen; busy shows one cycle later and
  // echo rises BURST_CYC cycles after acceptance, so BURST itself lasts BURST_CYC-1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dist_q       <= '0;
      width_q      <= '0;
      echo         <= 1'b0;
      busy         <= 1'b0;
      out_of_range <= 1'b0;
      short_trig   <= 1'b0;
      ignored_trig <= 1'b0;
    end else begin
      short_trig   <= 1'b0;
      ignored_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= TRIG_HI;
            cnt   <= ONE;
          end
        end
        TRIG_HI: begin
          if (fall) begin
            if (cnt >= TRIG_MIN) begin
              dist_q <= distance_cm;
              busy   <= 1'b1;
              state  <= BURST;
              cnt    <= ONE;
            end else begin
              short_trig <= 1'b1;
              state      <= IDLE;
              cnt        <= '0;
            end
          end else if (trig_s && (cnt != '1)) begin
            cnt <= cnt + ONE;
          end
        end
        BURST: begin
          if (rise) ignored_trig <= 1'b1;
          if (cnt == ONE) width_q <= in_range ? CNT_W'(prod) : TIMEOUT_W;
          if (cnt == BURST_LAST) begin
            echo         <= 1'b1;
            out_of_range <= ~in_range;
            state        <= ECHO;
            cnt          <= ONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ECHO: begin
          if (rise) ignored_trig <= 1'b1;
          if (cnt == width_q) begin
            echo  <= 1'b0;
            state <= HOLDOFF;
            cnt   <= ONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HOLDOFF: begin
          if (rise) ignored_trig <= 1'b1;
          if (cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
